// File: rtl/gdma_wdata.sv
// rtl/gdma_wdata.sv - GDMA write-data engine: GTP stream to AXI4 W/B channels toward DDR
// Segments the length-governed stream into bursts aligned with the AW engine and counts B responses.

module gdma_wdata #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] length,
  input  logic        op_start,
  input  logic        gdma_addr_done,
  output logic        gdma_done,
  input  logic [31:0] gdma_speed_divider,
  input  logic        gtp2gdma_tvalid,
  output logic        gtp2gdma_tready,
  input  logic [31:0] gtp2gdma_tdata,
  input  logic        gtp2gdma_tlast,
  output logic [31:0] gdma_ddr_wdata,
  output logic [3:0]  gdma_ddr_wstrb,
  output logic        gdma_ddr_wlast,
  output logic        gdma_ddr_wvalid,
  input  logic        gdma_ddr_wready,
  input  logic [1:0]  gdma_ddr_bresp,
  input  logic        gdma_ddr_bvalid,
  output logic        gdma_ddr_bready,
  output logic        err_slverr,
  output logic        err_tlast
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [29:0]   r_in_left;
  logic [29:0]   r_out_left;
  logic [29:0]   r_b_left;
  logic [BW-1:0] r_burst_beat;
  logic [31:0]   r_trans_cnt;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_err_slverr;
  logic          r_err_tlast;

  logic          w_run;
  logic          w_start;
  logic          w_full;
  logic          w_empty;
  logic          w_trans_en;
  logic          w_push;
  logic          w_pop;
  logic          w_b_ok;
  logic          w_b_err;
  logic          w_tlast_bad;
  logic          w_done_cond;
  logic [30:0]   w_bursts;
  logic          w_unused_bits;

  assign w_run   = (r_state == S_RUN);
  assign w_start = (r_state == S_IDLE) & op_start;

  // Burst count rounds up so a trailing short burst still expects its own B response.
  assign w_bursts      = ({1'b0, length[31:2]} + 31'(BURST_LEN - 1)) >> BW;
  assign w_unused_bits = ^{length[1:0], w_bursts[30]};

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) & (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_trans_en = (r_trans_cnt == 32'd0);

  assign gtp2gdma_tready = w_run & (r_in_left != 30'd0) & ~w_full;
  assign w_push          = gtp2gdma_tvalid & gtp2gdma_tready;
  assign w_tlast_bad     = gtp2gdma_tlast ^ (r_in_left == 30'd1);

  assign gdma_ddr_wvalid = w_run & ~w_empty & w_trans_en & (r_out_left != 30'd0);
  assign gdma_ddr_wdata  = r_mem[r_rd_ptr[AW-1:0]];
  assign gdma_ddr_wstrb  = 4'hF;
  assign gdma_ddr_wlast  = gdma_ddr_wvalid &
                           ((r_burst_beat == LAST_BEAT) | (r_out_left == 30'd1));
  assign w_pop           = gdma_ddr_wvalid & gdma_ddr_wready;

  // Responses outside a transfer or beyond the expected count are flagged, never counted.
  assign gdma_ddr_bready = 1'b1;
  assign w_b_ok          = gdma_ddr_bvalid & w_run & (r_b_left != 30'd0);
  assign w_b_err         = gdma_ddr_bvalid & ((gdma_ddr_bresp != 2'b00) | ~w_b_ok);

  assign w_done_cond = (r_out_left == 30'd0) & (r_b_left == 30'd0) & gdma_addr_done;

  assign gdma_done  = (r_state == S_IDLE);
  assign err_slverr = r_err_slverr;
  assign err_tlast  = r_err_tlast;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_done_cond) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_left    <= 30'd0;
      r_out_left   <= 30'd0;
      r_b_left     <= 30'd0;
      r_burst_beat <= '0;
      r_err_tlast  <= 1'b0;
      r_err_slverr <= 1'b0;
    end else begin
      if (w_start) begin
        r_in_left    <= length[31:2];
        r_out_left   <= length[31:2];
        r_b_left     <= w_bursts[29:0];
        r_burst_beat <= '0;
        r_err_tlast  <= 1'b0;
        r_err_slverr <= 1'b0;
      end else begin
        if (w_push) begin
          r_in_left <= r_in_left - 30'd1;
          if (w_tlast_bad) r_err_tlast <= 1'b1;
        end
        if (w_pop) begin
          r_out_left   <= r_out_left - 30'd1;
          r_burst_beat <= gdma_ddr_wlast ? '0 : r_burst_beat + 1'b1;
        end
        if (w_b_ok) r_b_left <= r_b_left - 30'd1;
      end
      if (w_b_err) r_err_slverr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trans_cnt <= 32'd0;
    end else if (w_trans_en) begin
      r_trans_cnt <= gdma_speed_divider;
    end else begin
      r_trans_cnt <= r_trans_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= gtp2gdma_tdata;
  end

endmodule

// File: tb/tb_gdma_wdata.sv
// tb/tb_gdma_wdata.sv - directed table-driven bench for gdma_wdata
// Each vector runs one complete transfer against a small stream/AXI slave model.

module tb_gdma_wdata;

  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] length;
  logic        op_start;
  logic        gdma_addr_done;
  logic        gdma_done;
  logic [31:0] gdma_speed_divider;
  logic        gtp2gdma_tvalid;
  logic        gtp2gdma_tready;
  logic [31:0] gtp2gdma_tdata;
  logic        gtp2gdma_tlast;
  logic [31:0] gdma_ddr_wdata;
  logic [3:0]  gdma_ddr_wstrb;
  logic        gdma_ddr_wlast;
  logic        gdma_ddr_wvalid;
  logic        gdma_ddr_wready;
  logic [1:0]  gdma_ddr_bresp;
  logic        gdma_ddr_bvalid;
  logic        gdma_ddr_bready;
  logic        err_slverr;
  logic        err_tlast;

  gdma_wdata #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .length(length), .op_start(op_start),
    .gdma_addr_done(gdma_addr_done), .gdma_done(gdma_done),
    .gdma_speed_divider(gdma_speed_divider),
    .gtp2gdma_tvalid(gtp2gdma_tvalid), .gtp2gdma_tready(gtp2gdma_tready),
    .gtp2gdma_tdata(gtp2gdma_tdata), .gtp2gdma_tlast(gtp2gdma_tlast),
    .gdma_ddr_wdata(gdma_ddr_wdata), .gdma_ddr_wstrb(gdma_ddr_wstrb),
    .gdma_ddr_wlast(gdma_ddr_wlast), .gdma_ddr_wvalid(gdma_ddr_wvalid),
    .gdma_ddr_wready(gdma_ddr_wready), .gdma_ddr_bresp(gdma_ddr_bresp),
    .gdma_ddr_bvalid(gdma_ddr_bvalid), .gdma_ddr_bready(gdma_ddr_bready),
    .err_slverr(err_slverr), .err_tlast(err_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [31:0] len;
    logic [31:0] div;
    int          wmod;
    bit          trand;
    int          tlast_beat;
    int          bad_burst;
    int          addr_delay;
    int          exp_beats;
    int          exp_wlast;
    int          exp_b;
    int          exp_etlast;
    int          exp_eslv;
    int          exp_gap;
    int          exp_occ;
  } vec_t;

  vec_t vecs[9];

  int checks   = 0;
  int failures = 0;

  int r_beats, r_wlast, r_b, r_data_err, r_wlast_err, r_flow_err;
  int r_min_gap, r_max_occ, r_done1, r_lat;

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ge(input string nm, input int act, input int lo);
    checks++;
    if (act < lo) begin
      failures++;
      $display("FAIL %s: got %0d expected at least %0d", nm, act, lo);
    end
  endtask

  task automatic run_xfer(input vec_t v, input int base);
    int n, pushed, popped, occ, bq, bsent, last_b, last_w, done_cyc, cyc, j, ev;
    bit exp_tr, exp_wl;
    n = int'(v.len[31:2]);
    pushed = 0; popped = 0; bq = 0; bsent = 0;
    last_b = -1; last_w = -1; done_cyc = -1;
    r_beats = 0; r_wlast = 0; r_b = 0; r_data_err = 0; r_wlast_err = 0; r_flow_err = 0;
    r_min_gap = 1000000; r_max_occ = 0; r_done1 = -1; r_lat = -1;
    @(posedge clk); #1;
    op_start = 1'b1;
    length = v.len;
    gdma_speed_divider = v.div;
    for (cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        op_start = 1'b0;
      end
      gdma_addr_done  = (cyc >= v.addr_delay);
      gtp2gdma_tvalid = (cyc > 0) && (pushed < n) && (!v.trand || $urandom_range(0, 7) != 0);
      gtp2gdma_tdata  = base + pushed;
      gtp2gdma_tlast  = (pushed + 1 == v.tlast_beat);
      gdma_ddr_wready = (cyc % v.wmod == 0);
      gdma_ddr_bvalid = (bq > 0);
      gdma_ddr_bresp  = (bsent + 1 == v.bad_burst) ? 2'b10 : 2'b00;
      @(negedge clk);
      occ = pushed - popped;
      if (cyc == 1) r_done1 = int'(gdma_done);
      if (cyc > 1 && gdma_done) done_cyc = cyc;
      if (cyc >= 1) begin
        exp_tr = (pushed < n) && (occ < FIFO_DEPTH);
        if (gtp2gdma_tready !== exp_tr) r_flow_err++;
      end
      if (gdma_ddr_wvalid && occ == 0) r_flow_err++;
      if (gdma_ddr_bready !== 1'b1) r_flow_err++;
      if (gtp2gdma_tvalid && gtp2gdma_tready) pushed++;
      if (gdma_ddr_wvalid && gdma_ddr_wready) begin
        popped++;
        j = popped;
        if (gdma_ddr_wdata !== 32'(base + j - 1)) r_data_err++;
        exp_wl = (j % BURST_LEN == 0) || (j == n);
        if (gdma_ddr_wlast !== exp_wl) r_wlast_err++;
        if (last_w >= 0 && cyc - last_w < r_min_gap) r_min_gap = cyc - last_w;
        last_w = cyc;
        if (gdma_ddr_wlast) begin
          r_wlast++;
          bq++;
        end
      end
      if (gdma_ddr_bvalid) begin
        bq--;
        bsent++;
        last_b = cyc;
      end
      if (pushed - popped > r_max_occ) r_max_occ = pushed - popped;
    end
    r_beats = popped;
    r_b = bsent;
    ev = (last_b + 1 > v.addr_delay) ? last_b + 1 : v.addr_delay;
    if (done_cyc >= 0) r_lat = done_cyc - ev;
    @(posedge clk); #1;
    gdma_addr_done  = 1'b0;
    gtp2gdma_tvalid = 1'b0;
    gtp2gdma_tlast  = 1'b0;
    gdma_ddr_wready = 1'b0;
    gdma_ddr_bvalid = 1'b0;
  endtask

  task automatic compare_row(input vec_t v);
    check_eq({v.name, ".beats"},      r_beats,     v.exp_beats);
    check_eq({v.name, ".wlast_cnt"},  r_wlast,     v.exp_wlast);
    check_eq({v.name, ".b_cnt"},      r_b,         v.exp_b);
    check_eq({v.name, ".data_err"},   r_data_err,  0);
    check_eq({v.name, ".wlast_pos"},  r_wlast_err, 0);
    check_eq({v.name, ".flow_err"},   r_flow_err,  0);
    check_eq({v.name, ".err_tlast"},  int'(err_tlast),  v.exp_etlast);
    check_eq({v.name, ".err_slverr"}, int'(err_slverr), v.exp_eslv);
    check_eq({v.name, ".done_fall"},  r_done1,     0);
    check_eq({v.name, ".done_lat"},   r_lat,       1);
    check_ge({v.name, ".w_gap"},      r_min_gap,   v.exp_gap);
    check_ge({v.name, ".max_occ"},    r_max_occ,   v.exp_occ);
  endtask

  initial begin
    vecs[0] = '{"basic",    32'd16,  32'd0, 1, 1'b0, 4,  0, 2,  4,  1, 1, 0, 0, 1, 1};
    vecs[1] = '{"multi",    32'd160, 32'd0, 1, 1'b0, 40, 0, 2,  40, 3, 3, 0, 0, 1, 1};
    vecs[2] = '{"backpr",   32'd160, 32'd0, 3, 1'b1, 40, 0, 2,  40, 3, 3, 0, 0, 3, 16};
    vecs[3] = '{"throttle", 32'd64,  32'd3, 1, 1'b0, 16, 0, 2,  16, 1, 1, 0, 0, 4, 1};
    vecs[4] = '{"short",    32'd71,  32'd0, 1, 1'b0, 17, 0, 2,  17, 2, 2, 0, 0, 1, 1};
    vecs[5] = '{"tlast",    32'd16,  32'd0, 1, 1'b0, 2,  0, 2,  4,  1, 1, 1, 0, 1, 1};
    vecs[6] = '{"slverr",   32'd160, 32'd0, 1, 1'b0, 40, 2, 2,  40, 3, 3, 0, 1, 1, 1};
    vecs[7] = '{"lateaddr", 32'd16,  32'd0, 1, 1'b0, 4,  0, 40, 4,  1, 1, 0, 0, 1, 1};
    vecs[8] = '{"zero",     32'd0,   32'd0, 1, 1'b0, 0,  0, 5,  0,  0, 0, 0, 0, 1, 0};

    rst = 1'b1;
    length = 32'd0;
    op_start = 1'b0;
    gdma_addr_done = 1'b0;
    gdma_speed_divider = 32'd0;
    gtp2gdma_tvalid = 1'b0;
    gtp2gdma_tdata = 32'd0;
    gtp2gdma_tlast = 1'b0;
    gdma_ddr_wready = 1'b0;
    gdma_ddr_bresp = 2'b00;
    gdma_ddr_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.done",   int'(gdma_done),       1);
    check_eq("rst.tready", int'(gtp2gdma_tready), 0);
    check_eq("rst.wvalid", int'(gdma_ddr_wvalid), 0);
    check_eq("rst.wlast",  int'(gdma_ddr_wlast),  0);
    check_eq("rst.bready", int'(gdma_ddr_bready), 1);
    check_eq("rst.wstrb",  int'(gdma_ddr_wstrb),  15);
    check_eq("rst.errs",   int'({err_slverr, err_tlast}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i], i * 256 + 1);
      compare_row(vecs[i]);
    end

    // Abort a 40-beat transfer with five words held in the FIFO.
    @(posedge clk); #1;
    op_start = 1'b1;
    length = 32'd160;
    gdma_speed_divider = 32'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      op_start = 1'b0;
      gtp2gdma_tvalid = 1'b1;
      gtp2gdma_tdata = 32'(900 + k);
      @(negedge clk);
      check_eq("abort.tready", int'(gtp2gdma_tready), 1);
    end
    @(posedge clk); #1;
    gtp2gdma_tvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("abort.done",   int'(gdma_done),       1);
    check_eq("abort.wvalid", int'(gdma_ddr_wvalid), 0);
    check_eq("abort.tready", int'(gtp2gdma_tready), 0);
    check_eq("abort.wlast",  int'(gdma_ddr_wlast),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort.idle_wvalid", int'(gdma_ddr_wvalid), 0);

    vecs[0].name = "postrst";
    run_xfer(vecs[0], 5000);
    compare_row(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
